// File: rtl/apb_regbank_slave.sv
// apb_regbank_slave: APB slave with an integrated register bank, wait states and error responses.
// Optional feature: define APB_STRB_EN to add the PSTRB port and per-byte-lane write masking.
// Ports:
//   PCLK, PRESET             clock (rising edge), asynchronous active-high reset
//   PSEL, PENABLE, PWRITE    APB control from the interconnect
//   PADDR, PWDATA, PSTRB     byte address, write data, byte strobes (PSTRB only with APB_STRB_EN)
//   PREADY, PRDATA, PSLVERR  APB response, all registered
//   hw_status                packed contents of read-only registers RO_BASE..NUM_REGS-1 (slice k = RO_BASE+k)
//   reg_q                    packed contents of read/write registers 0..RO_BASE-1 (slice k = register k)
//   wr_pulse                 one-cycle pulse per register after a committed write
// When RO_BASE is 0 or equal to NUM_REGS, the corresponding packed port keeps one unused word
// so that no zero-width port is ever declared.
module apb_regbank_slave #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int NUM_REGS    = 16,
    parameter int RO_BASE     = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
`ifdef APB_STRB_EN
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSLVERR,
    input  logic [((NUM_REGS > RO_BASE) ? (NUM_REGS - RO_BASE) : 1)*DATA_WIDTH-1:0] hw_status,
    output logic [((RO_BASE > 0) ? RO_BASE : 1)*DATA_WIDTH-1:0]                     reg_q,
    output logic [NUM_REGS-1:0]   wr_pulse
);
    localparam int NB   = DATA_WIDTH / 8;
    localparam int AB   = $clog2(NB);
    localparam int RW_N = (RO_BASE > 0) ? RO_BASE : 1;
    localparam int IW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] regs [RW_N];
    logic [2:0]            cnt;
    logic [IW-1:0]         idx_q;
    logic                  write_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0] rd_c;
    logic [NB-1:0]         strb_in;
    logic [NB-1:0]         strb_q;
    logic [ADDR_WIDTH-1:0] idx_c;
    logic                  err_c;
    logic                  strb_err;

`ifdef APB_STRB_EN
    assign strb_in  = PSTRB;
    // A read carries no data, so any asserted strobe marks a malformed access
    assign strb_err = !PWRITE && (PSTRB != '0);
`else
    assign strb_in  = '1;
    assign strb_err = 1'b0;
`endif

    assign idx_c = PADDR >> AB;
    assign err_c = (idx_c >= ADDR_WIDTH'(NUM_REGS))
                || ((PADDR & ADDR_WIDTH'(NB - 1)) != '0)
                || (PWRITE && (idx_c >= ADDR_WIDTH'(RO_BASE)))
                || strb_err;

    // Read value for the setup-phase address; hw_status is sampled here, never stored elsewhere
    always_comb begin
        rd_c = '0;
        for (int k = 0; k < RO_BASE; k++)
            if (idx_c == ADDR_WIDTH'(k)) rd_c = regs[k];
        for (int k = RO_BASE; k < NUM_REGS; k++)
            if (idx_c == ADDR_WIDTH'(k)) rd_c = hw_status[(k - RO_BASE)*DATA_WIDTH +: DATA_WIDTH];
    end

    function automatic logic [DATA_WIDTH-1:0] merge(
        input logic [DATA_WIDTH-1:0] old_v,
        input logic [DATA_WIDTH-1:0] new_v,
        input logic [NB-1:0]         strb
    );
        merge = old_v;
        for (int b = 0; b < NB; b++)
            if (strb[b]) merge[8*b +: 8] = new_v[8*b +: 8];
    endfunction

    generate
        if (RO_BASE > 0) begin : g_rq
            for (genvar i = 0; i < RO_BASE; i++) begin : g_w
                assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
            end
        end else begin : g_rq0
            assign reg_q = '0;
        end
    endgenerate

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state    <= IDLE;
            cnt      <= '0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
            rd_q     <= '0;
            PREADY   <= 1'b0;
            PSLVERR  <= 1'b0;
            PRDATA   <= '0;
            wr_pulse <= '0;
            for (int k = 0; k < RW_N; k++) regs[k] <= '0;
        end else begin
            wr_pulse <= '0;
            case (state)
                IDLE: begin
                    if (PSEL && !PENABLE) begin
                        idx_q   <= IW'(idx_c);
                        write_q <= PWRITE;
                        err_q   <= err_c;
                        wdata_q <= PWDATA;
                        strb_q  <= strb_in;
                        rd_q    <= rd_c;
                        cnt     <= 3'(WAIT_STATES);
                        if (WAIT_STATES == 0) begin
                            state   <= ACCESS;
                            PREADY  <= 1'b1;
                            PSLVERR <= err_c;
                            PRDATA  <= (err_c || PWRITE) ? '0 : rd_c;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!PSEL) begin
                        state <= IDLE;
                    end else if (cnt == 3'd1) begin
                        state   <= ACCESS;
                        PREADY  <= 1'b1;
                        PSLVERR <= err_q;
                        PRDATA  <= (err_q || write_q) ? '0 : rd_q;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                ACCESS: begin
                    if (!PSEL || PENABLE) begin
                        state   <= IDLE;
                        PREADY  <= 1'b0;
                        PSLVERR <= 1'b0;
                        PRDATA  <= '0;
                        // Only a real closing edge commits; a dropped PSEL discards the write
                        if (PSEL)
                            for (int k = 0; k < RO_BASE; k++)
                                if (write_q && !err_q && idx_q == IW'(k)) begin
                                    regs[k]     <= merge(regs[k], wdata_q, strb_q);
                                    wr_pulse[k] <= 1'b1;
                                end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
